instr_fetch_unit: RTL

- Upstream neighbour of the multicycle controller.
- Takes the PC value, runs the memory read handshake and latches the returned 16-bit instruction into the IR.
- Presents IR plus an ir_valid qualifier to the controller, which decodes IR[15:12] and IR[1:0].
- Counts completed fetches for debug.

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_if.sv | 17 +
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared types and constants for the fetch unit and its controller.
//   fetch_state_e  : IDLE / REQ, 1-bit encoding
//   NOP_IR         : instruction register value after reset
//   OPC_HI/OPC_LO  : opcode field slice, also used by the controller's decoder
package instr_fetch_unit_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    localparam logic [15:0] NOP_IR = 16'h0000;
    localparam int          OPC_HI = 15;
    localparam int          OPC_LO = 12;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory read handshake.
//   mem_addr  : fetch address (master -> slave)
//   mem_rd    : read strobe (master -> slave)
//   mem_rdata : read data, valid with mem_ready (slave -> master)
//   mem_ready : read completion, honoured only while mem_rd=1 (slave -> master)
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_addr, mem_rd, input mem_rdata, mem_ready);
    modport slave  (input mem_addr, mem_rd, output mem_rdata, mem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the instruction at the PC into IR through a read handshake.
//   clk, rst_n     : clock, asynchronous active-low reset
//   fetch_req_i    : fetch request, sampled only in IDLE
//   pc_in_i        : fetch address, captured when the request is accepted
//   flush_i        : abort any fetch in progress, highest priority
//   mem            : memory read handshake (master side)
//   ir_o           : instruction register
//   ir_valid_o     : ir holds a fresh, unconsumed instruction
//   busy_o         : high while a read is outstanding
//   fetch_err_o    : sticky timeout flag
//   fetch_count_o  : completed fetches, wraps
// Optional: define FETCH_TIMEOUT_EN to abort a read after MAX_WAIT wait cycles.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req_i,
    input  logic [ADDR_W-1:0]   pc_in_i,
    input  logic                flush_i,
    instr_fetch_unit_if.master  mem,
    output logic [DATA_W-1:0]   ir_o,
    output logic                ir_valid_o,
    output logic                busy_o,
    output logic                fetch_err_o,
    output logic [CNT_W-1:0]    fetch_count_o
);
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..255");
    end

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, done, timeout;

    assign accept = state_q == IDLE && fetch_req_i && !flush_i;
    assign done   = state_q == REQ && mem.mem_ready && !flush_i;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    // a ready arriving in the timeout cycle still completes the fetch
    assign timeout = state_q == REQ && !mem.mem_ready && wait_q == 8'(MAX_WAIT);
    assign wait_d  = accept ? 8'd0 : (state_q == REQ && !mem.mem_ready) ? wait_q + 8'd1 : wait_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wait_q <= 8'd0;
        else        wait_q <= wait_d;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = flush_i ? IDLE
                : state_q == IDLE ? (fetch_req_i ? REQ : IDLE)
                : (mem.mem_ready || timeout) ? IDLE : REQ;
    end

    // strobes derive straight from the state register, so a reset drops them at once
    always_comb begin
        mem.mem_rd = state_q == REQ;
        busy_o     = state_q == REQ;
    end

    assign addr_d  = accept ? pc_in_i : addr_q;
    assign ir_d    = done ? mem.mem_rdata : ir_q;
    assign valid_d = (flush_i || accept) ? 1'b0 : done ? 1'b1 : valid_q;
    assign err_d   = accept ? 1'b0 : (timeout && !flush_i) ? 1'b1 : err_q;
    assign cnt_d   = done ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q  <= '0;
            ir_q    <= DATA_W'(NOP_IR);
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end

    assign mem.mem_addr  = addr_q;
    assign ir_o          = ir_q;
    assign ir_valid_o    = valid_q;
    assign fetch_err_o   = err_q;
    assign fetch_count_o = cnt_q;
endmodule
